// File: rtl/ttl_pkg.sv
// Shared constants and types for the TTL-style clock-enable generator.
// The sum/compare width carries one guard bit so acc + num never truncates.
package ttl_pkg;

  localparam int ACCW_DEFAULT = 16;
  localparam int SUM_GUARD    = 1;

  function automatic int sum_width(input int accw);
    return accw + SUM_GUARD;
  endfunction

  typedef enum logic [2:0] {
    ACC_HOLD,
    ACC_CLEAR,
    ACC_ADD,
    ACC_TICK_SUB,
    ACC_TICK_SAT
  } acc_op_e;

endpackage

// File: rtl/ttl_frac_acc.sv
// Fractional phase accumulator: emits a tick whenever acc + num reaches den,
// giving an exact long-run rate of num/den ticks per enabled cycle.
module ttl_frac_acc
  import ttl_pkg::*;
#(
  parameter int ACCW = ACCW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ACCW-1:0] num,
  input  logic [ACCW-1:0] den,
  input  logic            enable,
  input  logic            clear,
  output logic            tick,
  output logic [ACCW-1:0] acc,
  output logic            tick_nxt
);

  localparam int SUMW = sum_width(ACCW);

  logic [SUMW-1:0] sum_w;
  logic [SUMW-1:0] den_w;
  logic [ACCW-1:0] acc_q;
  logic [ACCW-1:0] acc_d;
  logic            tick_q;
  acc_op_e         op;

  assign sum_w = SUMW'(acc_q) + SUMW'(num);
  assign den_w = SUMW'(den);

  // num >= den saturates to a tick every cycle with acc pinned at 0, so a
  // large num can never leave a residue that would demand a second tick.
  always_comb begin
    op = ACC_HOLD;
    if (clear) begin
      op = ACC_CLEAR;
    end else if (enable && (den != '0) && (num != '0)) begin
      if (num >= den) begin
        op = ACC_TICK_SAT;
      end else if (sum_w >= den_w) begin
        op = ACC_TICK_SUB;
      end else begin
        op = ACC_ADD;
      end
    end
  end

  // The true result of acc + num - den always fits in ACCW bits here, so
  // modular ACCW-bit arithmetic yields it exactly.
  always_comb begin
    acc_d = acc_q;
    case (op)
      ACC_CLEAR:    acc_d = '0;
      ACC_ADD:      acc_d = acc_q + num;
      ACC_TICK_SUB: acc_d = acc_q + num - den;
      ACC_TICK_SAT: acc_d = '0;
      default:      acc_d = acc_q;
    endcase
  end

  assign tick_nxt = (op == ACC_TICK_SUB) || (op == ACC_TICK_SAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_nxt;
    end
  end

  assign tick = tick_q;
  assign acc  = acc_q;

endmodule

// File: rtl/ttl_cen_gen.sv
// Binary-weighted TTL clock emulation: a tick-driven counter whose bits act as
// clock levels, with registered one-cycle rising/falling edge pulses per bit.
module ttl_cen_gen
  import ttl_pkg::*;
#(
  parameter int W    = 2,
  parameter int ACCW = ACCW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ACCW-1:0] num,
  input  logic [ACCW-1:0] den,
  input  logic            enable,
  input  logic            sync_clr,
  output logic [W-1:0]    cen_lvl,
  output logic [W-1:0]    cen_p,
  output logic [W-1:0]    cen_n,
  output logic            tick
);

  logic            tick_nxt;
  logic [ACCW-1:0] acc_unused;
  logic [W-1:0]    cnt_q;
  logic [W-1:0]    cnt_d;
  logic [W-1:0]    cen_p_q;
  logic [W-1:0]    cen_n_q;

  ttl_frac_acc #(
    .ACCW(ACCW)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .num     (num),
    .den     (den),
    .enable  (enable),
    .clear   (sync_clr),
    .tick    (tick),
    .acc     (acc_unused),
    .tick_nxt(tick_nxt)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (sync_clr) begin
      cnt_d = '0;
    end else if (tick_nxt) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Pulses come from comparing old and new levels, so a clear naturally
  // produces cen_n for every bit that was high and never a cen_p.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      cen_p_q <= '0;
      cen_n_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      cen_p_q <= cnt_d & ~cnt_q;
      cen_n_q <= ~cnt_d & cnt_q;
    end
  end

  assign cen_lvl = cnt_q;
  assign cen_p   = cen_p_q;
  assign cen_n   = cen_n_q;

endmodule

// File: tb/tb_ttl_cen_gen.sv
// Self-checking bench for ttl_cen_gen: directed literal scenarios plus a long
// randomized run compared every cycle against an integer-arithmetic model.
module tb_ttl_cen_gen;

  localparam int W    = 2;
  localparam int ACCW = 16;

  logic            clk;
  logic            rst;
  logic [ACCW-1:0] num;
  logic [ACCW-1:0] den;
  logic            enable;
  logic            sync_clr;
  logic [W-1:0]    cen_lvl;
  logic [W-1:0]    cen_p;
  logic [W-1:0]    cen_n;
  logic            tick;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 0;

  longint      mAcc;
  int          mCnt;
  bit          mTick;
  bit [W-1:0]  mLvl;
  bit [W-1:0]  mP;
  bit [W-1:0]  mN;

  ttl_cen_gen #(
    .W   (W),
    .ACCW(ACCW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .num     (num),
    .den     (den),
    .enable  (enable),
    .sync_clr(sync_clr),
    .cen_lvl (cen_lvl),
    .cen_p   (cen_p),
    .cen_n   (cen_n),
    .tick    (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int n, input int d, input bit en, input bit sc);
    num      = ACCW'(n);
    den      = ACCW'(d);
    enable   = en;
    sync_clr = sc;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    rst = 1'b0;
    applyStimulus(0, 0, 1'b0, 1'b0);
    repeat (2) stepCycle();
    rst = 1'b1;
  endtask

  // Reference: rate-num/den accumulator in plain integers, counter modulo 2^W,
  // and edge pulses derived by comparing counter bits before and after.
  task automatic modelStep();
    int prev;
    bit fire;
    prev = mCnt;
    fire = 1'b0;
    if (sync_clr) begin
      mAcc = 0;
      mCnt = 0;
    end else if (enable) begin
      if (num != 0 && den != 0) begin
        if (longint'(num) >= longint'(den)) begin
          fire = 1'b1;
          mAcc = 0;
        end else if (mAcc + longint'(num) >= longint'(den)) begin
          fire = 1'b1;
          mAcc = mAcc + longint'(num) - longint'(den);
        end else begin
          mAcc = mAcc + longint'(num);
        end
      end
      if (fire) mCnt = (mCnt + 1) % (1 << W);
    end
    mTick = fire;
    for (int i = 0; i < W; i++) begin
      mP[i] = !prev[i] && mCnt[i];
      mN[i] = prev[i] && !mCnt[i];
    end
    mLvl = mCnt[W-1:0];
  endtask

  initial begin
    mAcc = 0; mCnt = 0; mTick = 0; mLvl = '0; mP = '0; mN = '0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mAcc = 0; mCnt = 0; mTick = 0; mLvl = '0; mP = '0; mN = '0;
      end else begin
        modelStep();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) begin
        checkOutput("model_tick", 64'(tick), 64'(mTick));
        checkOutput("model_lvl", 64'(cen_lvl), 64'(mLvl));
        checkOutput("model_cen_p", 64'(cen_p), 64'(mP));
        checkOutput("model_cen_n", 64'(cen_n), 64'(mN));
      end
    end
  end

  task automatic midCycleReset();
    #1;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_outputs", 64'({tick, cen_lvl, cen_p, cen_n}), 64'd0);
    #4;
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] pat8;
    logic [9:0] pat10;
    logic [3:0] pat4;
    logic [W-1:0] pulseOr;
    int cntA;
    int cntB;
    logic lastLvl0;

    rst = 1'b0;
    applyStimulus(0, 0, 1'b0, 1'b0);
    stepCycle();
    checkEn = 1'b1;
    checkOutput("reset_state", 64'({tick, cen_lvl, cen_p, cen_n}), 64'd0);

    // 3/8: fixed tick pattern from reset
    doReset();
    applyStimulus(3, 8, 1'b1, 1'b0);
    pat8 = '0;
    for (int k = 0; k < 8; k++) begin
      stepCycle();
      pat8[7-k] = tick;
    end
    checkOutput("pattern_3_8", 64'(pat8), 64'b00100101);

    // 1/4: tick every 4th cycle, bit 1 rises every 16
    doReset();
    applyStimulus(1, 4, 1'b1, 1'b0);
    cntA = 0; cntB = 0;
    for (int k = 0; k < 64; k++) begin
      stepCycle();
      if (cen_p[1]) cntA++;
      if (tick) cntB++;
    end
    checkOutput("rate_1_4_cen_p1", 64'(cntA), 64'd4);
    checkOutput("rate_1_4_ticks", 64'(cntB), 64'd16);

    // num >= den saturates; den = 0 stops ticking
    doReset();
    applyStimulus(9, 5, 1'b1, 1'b0);
    cntA = 0; cntB = 0; lastLvl0 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      stepCycle();
      if (tick) cntA++;
      if (cen_lvl[0] != lastLvl0) cntB++;
      lastLvl0 = cen_lvl[0];
    end
    checkOutput("sat_9_5_ticks", 64'(cntA), 64'd20);
    checkOutput("sat_9_5_toggles", 64'(cntB), 64'd20);
    applyStimulus(5, 5, 1'b1, 1'b0);
    cntA = 0;
    for (int k = 0; k < 20; k++) begin
      stepCycle();
      if (tick) cntA++;
    end
    checkOutput("sat_5_5_ticks", 64'(cntA), 64'd20);
    applyStimulus(1, 0, 1'b1, 1'b0);
    cntA = 0;
    for (int k = 0; k < 100; k++) begin
      stepCycle();
      if (tick) cntA++;
    end
    checkOutput("den_zero_ticks", 64'(cntA), 64'd0);

    // sync_clr on a tick cycle with both levels high
    doReset();
    applyStimulus(5, 5, 1'b1, 1'b0);
    repeat (3) stepCycle();
    checkOutput("pre_clr_lvl", 64'(cen_lvl), 64'd3);
    applyStimulus(5, 5, 1'b1, 1'b1);
    stepCycle();
    checkOutput("clr_outputs", 64'({tick, cen_lvl, cen_p, cen_n}), 64'b0_00_00_11);
    applyStimulus(5, 5, 1'b1, 1'b0);

    // den lowered 8 -> 2 with acc = 6
    doReset();
    applyStimulus(1, 8, 1'b1, 1'b0);
    repeat (6) stepCycle();
    applyStimulus(1, 2, 1'b1, 1'b0);
    pat10 = '0;
    for (int k = 0; k < 10; k++) begin
      stepCycle();
      pat10[9-k] = tick;
    end
    checkOutput("den_drop_pattern", 64'(pat10), 64'b1111110101);

    // asynchronous reset between edges, then first tick after den cycles
    midCycleReset();
    applyStimulus(1, 4, 1'b1, 1'b0);
    pat4 = '0; pulseOr = '0;
    for (int k = 0; k < 4; k++) begin
      stepCycle();
      pat4[3-k] = tick;
      if (k < 3) pulseOr = pulseOr | cen_p | cen_n;
    end
    checkOutput("post_reset_ticks", 64'(pat4), 64'b0001);
    checkOutput("post_reset_no_pulse", 64'(pulseOr), 64'd0);

    // randomized run against the model
    applyStimulus($urandom_range(1, 6), $urandom_range(1, 10), 1'b1, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 7) == 0) begin
          num = ACCW'($urandom_range(0, 65535));
          den = ACCW'($urandom_range(0, 65535));
        end else begin
          num = ACCW'($urandom_range(0, 12));
          den = ACCW'($urandom_range(0, 12));
        end
      end
      enable   = ($urandom_range(0, 9) != 0);
      sync_clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) begin
        midCycleReset();
      end
      stepCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ttl_cen_gen.md
TTL_CEN_GEN -- requirements
Module: ttl_cen_gen

Interface
REQ-001 SHALL have parameter W, default 2: number of binary-weighted clock-enable outputs.
REQ-002 SHALL have parameter ACCW, default 16: width of the rate numerator, denominator and phase accumulator.
REQ-003 SHALL have port clk, input, 1: single master clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port num, input, ACCW: tick-rate numerator.
REQ-006 SHALL have port den, input, ACCW: tick-rate denominator.
REQ-007 SHALL have port enable, input, 1: advance accumulator and counter when high.
REQ-008 SHALL have port sync_clr, input, 1: synchronous phase restart.
REQ-009 SHALL have port cen_lvl, output, W: emulated TTL clock levels for downstream edge-detecting flip-flops.
REQ-010 SHALL have port cen_p, output, W: one-cycle pulse per cen_lvl rising edge.
REQ-011 SHALL have port cen_n, output, W: one-cycle pulse per cen_lvl falling edge.
REQ-012 SHALL have port tick, output, 1: registered base-tick strobe.

Function
REQ-013 SHALL compute sum = acc + num at ACCW+1 bits; no truncation before the compare.
REQ-014 When enable=1, den!=0 and sum>=den, SHALL assert tick on the next edge and load acc with sum-den; otherwise, when enable=1, SHALL load acc with sum.
REQ-015 When num>=den and den!=0, SHALL tick every enabled cycle and hold acc at 0 (saturate, no double tick).
REQ-016 When den=0 or num=0, SHALL never tick; acc SHALL hold.
REQ-017 Long-run tick rate SHALL equal num/den exactly; ticks within any window of den enabled cycles SHALL be floor or ceil of num.
REQ-018 Internal W-bit counter cnt SHALL increment by 1 per tick and wrap from all-ones to 0.
REQ-019 cen_lvl SHALL equal cnt, registered, updated on the same edge as tick.
REQ-020 On the edge where bit i goes 0->1, cen_p[i] SHALL be set; on the edge where it goes 1->0, cen_n[i] SHALL be set; both last exactly one cycle.
REQ-021 On counter wrap, all bits that fall SHALL pulse cen_n together.
REQ-022 When enable=0, acc and cnt SHALL hold; tick, cen_p and cen_n SHALL be 0.
REQ-023 sync_clr=1 SHALL override enable and any pending tick: acc<=0, cnt<=0, tick<=0, cen_p<=0.
REQ-024 Under sync_clr=1, cen_n[i] SHALL pulse for each cen_lvl bit that was 1.
REQ-025 num and den SHALL be sampled every cycle; a change SHALL take effect at the next compare with acc retained.
REQ-026 If the retained acc >= the new den, SHALL tick and subtract once per cycle until acc < den.
REQ-027 Latency: inputs on cycle N SHALL be reflected on all outputs after edge N+1; no combinational input-to-output path.

Reset
REQ-028 rst=0 SHALL immediately, independent of clk, force acc=0, cnt=0, cen_lvl=0, cen_p=0, cen_n=0 and tick=0.
REQ-029 Reset release SHALL NOT generate any pulse.
REQ-030 The first tick after release SHALL follow REQ-014 starting from acc=0.

Structure
REQ-031 Shared package ttl_pkg SHALL hold the ACCW default and the accumulator sum/compare width constant.
REQ-032 Accumulator and compare SHALL be one sub-module, ttl_frac_acc (inputs num, den, enable, clear; outputs tick and acc).
REQ-033 Counter and edge pulse logic SHALL live in ttl_cen_gen.

Verification
REQ-034 W=2, num=1, den=4, enable=1 -> tick every 4th cycle; cen_lvl[0] period 8 cycles; cen_p[1] every 16 cycles.
REQ-035 num=3, den=8 -> exactly 3 ticks per 8 cycles, repeating pattern 0,0,1,0,0,1,0,1 from reset; cen_p/cen_n alternate on bit 0.
REQ-036 num=5, den=5 and num=9, den=5 -> tick every cycle; cen_lvl[0] toggles every cycle; den=0 -> no tick for 100 cycles.
REQ-037 sync_clr asserted on a tick cycle with cen_lvl=2'b11 -> next cycle cen_lvl=0, cen_n=2'b11, cen_p=0, tick=0.
REQ-038 rst pulsed low mid-period (between clk edges) -> outputs 0 before the next edge; no pulse at release; first tick after den cycles for num=1.
REQ-039 den lowered from 8 to 2 with acc=6 -> consecutive ticks until acc<2, then rate 1/2 for num=1.
